subordinate_mem: RTL and testbench

SUBORDINATE_MEM -- requirements
Module: subordinate_mem

---
 rtl/subordinate_mem_if.sv | 34 +++
 rtl/subordinate_mem.sv | 144 ++++++++++++++
 tb/tb_subordinate_mem.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/subordinate_mem_if.sv
// AXI4-Lite channel bundle between a manager and the subordinate_mem block.
// Clock and reset stay outside the bundle as plain ports.
interface subordinate_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/subordinate_mem.sv
// AXI4-Lite subordinate backed by a word-addressed RAM with byte strobes.
// AW and W are captured independently; reads and writes proceed concurrently.
module subordinate_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input logic              ACLK,
  input logic              ARESETn,
  subordinate_mem_if.slave io_axi
);
  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned OffsW = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RResp} r_state_e;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  w_state_e          r_wstate;
  r_state_e          r_rstate;
  logic              r_aw_held;
  logic [ADDR_W-1:0] r_aw_addr;
  logic              r_w_held;
  logic [DATA_W-1:0] r_w_data;
  logic [StrbW-1:0]  r_w_strb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic [ADDR_W-1:0] w_aw_idx;
  logic [ADDR_W-1:0] w_ar_idx;
  logic              w_aw_in_range;
  logic              w_ar_in_range;
  logic              w_awready;
  logic              w_wready;
  logic              w_arready;
  logic              w_commit;

  assign w_aw_idx      = r_aw_addr >> OffsW;
  assign w_ar_idx      = io_axi.ARADDR >> OffsW;
  assign w_aw_in_range = w_aw_idx < ADDR_W'(MEM_DEPTH);
  assign w_ar_in_range = w_ar_idx < ADDR_W'(MEM_DEPTH);

  // Ready signals depend on state registers only, never on VALID inputs.
  assign w_awready = !r_aw_held && (r_wstate == WIdle);
  assign w_wready  = !r_w_held && (r_wstate == WIdle);
  assign w_arready = (r_rstate == RIdle);
  assign w_commit  = (r_wstate == WIdle) && r_aw_held && r_w_held;

  assign io_axi.AWREADY = w_awready;
  assign io_axi.WREADY  = w_wready;
  assign io_axi.ARREADY = w_arready;
  assign io_axi.BVALID  = r_bvalid;
  assign io_axi.BRESP   = r_bresp;
  assign io_axi.RVALID  = r_rvalid;
  assign io_axi.RRESP   = r_rresp;
  assign io_axi.RDATA   = r_rdata;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate  <= WIdle;
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RespOkay;
    end else begin
      if (io_axi.AWVALID && w_awready) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= io_axi.AWADDR;
      end
      if (io_axi.WVALID && w_wready) begin
        r_w_held <= 1'b1;
        r_w_data <= io_axi.WDATA;
        r_w_strb <= io_axi.WSTRB;
      end
      unique case (r_wstate)
        WIdle: begin
          if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_aw_in_range ? RespOkay : RespSlvErr;
            r_wstate  <= WResp;
          end
        end
        WResp: begin
          if (io_axi.BREADY) begin
            r_bvalid <= 1'b0;
            r_wstate <= WIdle;
          end
        end
        default: r_wstate <= WIdle;
      endcase
    end
  end

  // Storage is intentionally outside the reset domain so contents survive reset.
  always_ff @(posedge ACLK) begin
    if (w_commit && w_aw_in_range) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (r_w_strb[b]) begin
          r_mem[w_aw_idx[IdxW-1:0]][8*b +: 8] <= r_w_data[8*b +: 8];
        end
      end
    end
  end

  // Nonblocking read of r_mem yields pre-write data when a commit hits the same word.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate <= RIdle;
      r_rvalid <= 1'b0;
      r_rresp  <= RespOkay;
      r_rdata  <= '0;
    end else begin
      unique case (r_rstate)
        RIdle: begin
          if (io_axi.ARVALID) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_in_range ? RespOkay : RespSlvErr;
            r_rdata  <= w_ar_in_range ? r_mem[w_ar_idx[IdxW-1:0]] : '0;
            r_rstate <= RResp;
          end
        end
        RResp: begin
          if (io_axi.RREADY) begin
            r_rvalid <= 1'b0;
            r_rstate <= RIdle;
          end
        end
        default: r_rstate <= RIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_subordinate_mem.sv
// Directed bench for subordinate_mem: drives and samples on the falling edge,
// so each tick() advances exactly one rising edge of the DUT.
module tb_subordinate_mem;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  subordinate_mem_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  subordinate_mem #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .io_axi  (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // AW and W in the same cycle with BREADY high.
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] resp);
    chk({tag, ".awready"}, 64'(bus.AWREADY), 64'd1);
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk({tag, ".bv_early"}, 64'(bus.BVALID), 64'd0);
    tick();
    chk({tag, ".bvalid"}, 64'(bus.BVALID), 64'd1);
    chk({tag, ".bresp"}, 64'(bus.BRESP), 64'(resp));
    tick();
    chk({tag, ".bv_clr"}, 64'(bus.BVALID), 64'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] resp);
    chk({tag, ".arready"}, 64'(bus.ARREADY), 64'd1);
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    tick();
    bus.ARVALID = 1'b0;
    chk({tag, ".rvalid"}, 64'(bus.RVALID), 64'd1);
    chk({tag, ".rdata"}, 64'(bus.RDATA), 64'(d));
    chk({tag, ".rresp"}, 64'(bus.RRESP), 64'(resp));
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    chk({tag, ".rv_clr"}, 64'(bus.RVALID), 64'd0);
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    // Reset state
    #2;
    chk("rst.awready", 64'(bus.AWREADY), 64'd1);
    chk("rst.wready", 64'(bus.WREADY), 64'd1);
    chk("rst.arready", 64'(bus.ARREADY), 64'd1);
    chk("rst.bvalid", 64'(bus.BVALID), 64'd0);
    chk("rst.rvalid", 64'(bus.RVALID), 64'd0);
    chk("rst.bresp", 64'(bus.BRESP), 64'd0);
    chk("rst.rresp", 64'(bus.RRESP), 64'd0);
    chk("rst.rdata", 64'(bus.RDATA), 64'd0);
    tick(); tick();
    ARESETn = 1'b1;
    tick();

    // Basic write then read
    wr("w10", 32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    rd("r10", 32'h10, 32'hDEADBEEF, 2'b00);

    // W leads AW by three cycles, single-byte strobe
    bus.WDATA = 32'h000000AA; bus.WSTRB = 4'b0001; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    chk("wfirst.wready1", 64'(bus.WREADY), 64'd0);
    chk("wfirst.awready", 64'(bus.AWREADY), 64'd1);
    tick();
    chk("wfirst.wready2", 64'(bus.WREADY), 64'd0);
    tick();
    chk("wfirst.wready3", 64'(bus.WREADY), 64'd0);
    chk("wfirst.bv_none", 64'(bus.BVALID), 64'd0);
    bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    chk("wfirst.wready4", 64'(bus.WREADY), 64'd0);
    chk("wfirst.bv_early", 64'(bus.BVALID), 64'd0);
    tick();
    chk("wfirst.bvalid", 64'(bus.BVALID), 64'd1);
    chk("wfirst.bresp", 64'(bus.BRESP), 64'd0);
    tick();
    chk("wfirst.wready_back", 64'(bus.WREADY), 64'd1);
    rd("r10b", 32'h10, 32'hDEADBEAA, 2'b00);

    // Out-of-range write aliasing word 0 must not touch it
    wr("w0", 32'h0, 32'hCAFEF00D, 4'hF, 2'b00);
    wr("woor", 32'h1000, 32'h12345678, 4'hF, 2'b10);
    rd("r0", 32'h0, 32'hCAFEF00D, 2'b00);
    rd("roor", 32'h1000, 32'h0, 2'b10);

    // B backpressure; second AW offered while response is pending
    bus.BREADY = 1'b0;
    bus.AWADDR = 32'h30; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hA5A5A5A5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    bus.AWADDR = 32'h34;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.bvalid%0d", i), 64'(bus.BVALID), 64'd1);
      chk($sformatf("bp.bresp%0d", i), 64'(bus.BRESP), 64'd0);
      chk($sformatf("bp.awready%0d", i), 64'(bus.AWREADY), 64'd0);
      chk($sformatf("bp.wready%0d", i), 64'(bus.WREADY), 64'd0);
      tick();
    end
    bus.BREADY = 1'b1;
    tick();
    chk("bp.bv_clr", 64'(bus.BVALID), 64'd0);
    chk("bp.aw_open", 64'(bus.AWREADY), 64'd1);
    tick();
    bus.AWVALID = 1'b0;
    chk("bp.aw_taken", 64'(bus.AWREADY), 64'd0);
    bus.WDATA = 32'h0F0F0F0F; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    tick();
    chk("bp.bvalid2", 64'(bus.BVALID), 64'd1);
    tick();
    rd("r30", 32'h30, 32'hA5A5A5A5, 2'b00);
    rd("r34", 32'h34, 32'h0F0F0F0F, 2'b00);

    // Read and commit on the same word at the same edge
    wr("w20", 32'h20, 32'h11111111, 4'hF, 2'b00);
    bus.BREADY = 1'b0;
    bus.AWADDR = 32'h20; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h55555555; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 32'h20; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    chk("rw.rvalid", 64'(bus.RVALID), 64'd1);
    chk("rw.bvalid", 64'(bus.BVALID), 64'd1);
    chk("rw.rdata_old", 64'(bus.RDATA), 64'h11111111);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    rd("rw.new", 32'h20, 32'h55555555, 2'b00);

    // Reset with AW held and R pending discards both
    wr("w40", 32'h40, 32'h40404040, 4'hF, 2'b00);
    bus.AWADDR = 32'h40; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    chk("mid.aw_held", 64'(bus.AWREADY), 64'd0);
    bus.ARADDR = 32'h10; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    chk("mid.rvalid", 64'(bus.RVALID), 64'd1);
    #2 ARESETn = 1'b0;
    #1;
    chk("mid.rst_rvalid", 64'(bus.RVALID), 64'd0);
    chk("mid.rst_awready", 64'(bus.AWREADY), 64'd1);
    chk("mid.rst_rdata", 64'(bus.RDATA), 64'd0);
    tick();
    ARESETn = 1'b1;
    tick();
    bus.WDATA = 32'h77777777; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    tick(); tick();
    chk("mid.no_commit", 64'(bus.BVALID), 64'd0);
    chk("mid.w_waiting", 64'(bus.WREADY), 64'd0);
    bus.AWADDR = 32'h44; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    tick();
    chk("mid.bvalid", 64'(bus.BVALID), 64'd1);
    tick();
    rd("r40", 32'h40, 32'h40404040, 2'b00);
    rd("r44", 32'h44, 32'h77777777, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
